// File: rtl/sdram_user_responder.sv
// sdram_user_responder
//
// Stand-in for the SDRAM controller user port. An on-chip word memory backs
// the port, and the block reproduces the controller's visible timing: ready
// stays low during init, each command holds ready low for a fixed latency, and
// periodic refresh stalls are inserted between commands.
//
// Ports:
//   clk        : single clock, all state on the rising edge
//   rst_n      : asynchronous active-low reset
//   enable     : command request, level-sensitive
//   write      : 1 = write, 0 = read (sampled with enable)
//   addr       : word address, only addr[AW-1:0] is used
//   write_data : write word (sampled with enable)
//   read_data  : last completed read word
//   ready      : 1 = idle, a command can be accepted
//   cmd_count  : completed commands (reads + writes), wraps
//   state_dbg  : current FSM state (INIT=0, IDLE=1, BUSY=2, REFRESH=3)
//
// Handshake: a command is accepted on any rising edge where ready is high,
// no refresh is pending and enable is high. The requester keeps enable,
// write, addr and write_data stable until it sees ready low. Holding enable
// across completion issues the next command on the first IDLE edge.
module sdram_user_responder #(
    parameter int AW             = 10,
    parameter int INIT_CYCLES    = 16,
    parameter int WR_LATENCY     = 4,
    parameter int RD_LATENCY     = 6,
    parameter int REFRESH_PERIOD = 512,
    parameter int REFRESH_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        write,
    input  logic [23:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [15:0] cmd_count,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_BUSY    = 2'd2,
        ST_REFRESH = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;          // init up-counter / busy+refresh down-counter
    logic [15:0]   ref_cnt_q, ref_cnt_d;  // free-running refresh timer
    logic          ref_pend_q, ref_pend_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   read_data_q, read_data_d;
    logic          ready_q, ready_d;
    logic [15:0]   cmd_count_q, cmd_count_d;
    logic          mem_we;
    logic          enter_refresh;
    logic          ref_wrap;

    logic [31:0]   mem_q [0:(2**AW)-1];

    // Upper address bits alias silently onto the low AW bits.
    logic          unused_addr_hi;
    assign unused_addr_hi = ^addr[23:AW];

    assign ref_wrap = (ref_cnt_q == 16'(REFRESH_PERIOD - 1));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wr_d          = wr_q;
        idx_d         = idx_q;
        wdata_d       = wdata_q;
        read_data_d   = read_data_q;
        cmd_count_d   = cmd_count_q;
        mem_we        = 1'b0;
        enter_refresh = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (cnt_q == 16'(INIT_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_IDLE: begin
                // Refresh beats a simultaneous request; a held enable is
                // picked up after the refresh completes.
                if (ref_pend_q) begin
                    state_d       = ST_REFRESH;
                    cnt_d         = 16'(REFRESH_CYCLES);
                    enter_refresh = 1'b1;
                end else if (enable) begin
                    state_d = ST_BUSY;
                    wr_d    = write;
                    idx_d   = addr[AW-1:0];
                    wdata_d = write_data;
                    cnt_d   = write ? 16'(WR_LATENCY) : 16'(RD_LATENCY);
                end
            end
            ST_BUSY: begin
                if (cnt_q == 16'd1) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    cmd_count_d = cmd_count_q + 16'd1;
                    if (wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        read_data_d = mem_q[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_REFRESH: begin
                if (cnt_q == 16'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = ST_INIT;
        endcase

        ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 16'd1;
        // A new wrap wins over the clear so a request is never lost.
        if (ref_wrap) begin
            ref_pend_d = 1'b1;
        end else if (enter_refresh) begin
            ref_pend_d = 1'b0;
        end else begin
            ref_pend_d = ref_pend_q;
        end

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            ref_cnt_q   <= '0;
            ref_pend_q  <= 1'b0;
            wr_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
            ready_q     <= 1'b0;
            cmd_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ref_cnt_q   <= ref_cnt_d;
            ref_pend_q  <= ref_pend_d;
            wr_q        <= wr_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
            ready_q     <= ready_d;
            cmd_count_q <= cmd_count_d;
        end
    end

    // Memory contents survive reset; mem_we is low while reset holds INIT,
    // so a write interrupted by reset is never committed.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign read_data = read_data_q;
    assign ready     = ready_q;
    assign cmd_count = cmd_count_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sdram_user_responder.sv
module tb_sdram_user_responder;

  localparam int AW    = 12;
  localparam int INITC = 16;
  localparam int WRL   = 4;
  localparam int RDL   = 6;
  localparam int RP    = 64;
  localparam int RC    = 8;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        write = 1'b0;
  logic [23:0] addr = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [15:0] cmd_count;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  sdram_user_responder #(
    .AW(AW), .INIT_CYCLES(INITC), .WR_LATENCY(WRL), .RD_LATENCY(RDL),
    .REFRESH_PERIOD(RP), .REFRESH_CYCLES(RC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .write(write), .addr(addr),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .cmd_count(cmd_count), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt = '0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input logic lvl);
    int n = 0;
    while (ready !== lvl && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (ready !== lvl) chk("wait_timeout", {31'b0, ready}, {31'b0, lvl});
  endtask

  // Returns at the negedge where ready is first seen high after a refresh.
  task automatic sync_refresh();
    enable = 1'b0;
    wait_ready(1'b0);
    wait_ready(1'b1);
  endtask

  // Counts cycles ready stays low, from the negedge after acceptance.
  task automatic count_low(output int lat);
    lat = 0;
    while (ready == 1'b0 && lat < 300) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic do_cmd(input logic wr, input logic [23:0] a, input logic [31:0] d, output int lat);
    write = wr;
    addr = a;
    write_data = d;
    enable = 1'b1;
    @(negedge clk);
    chk("accept_ready_low", {31'b0, ready}, 32'd0);
    enable = 1'b0;
    write_data = ~d;
    addr = ~a;
    count_low(lat);
  endtask

  task automatic do_reset();
    int n;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    chk("reset_ready", {31'b0, ready}, 32'd0);
    chk("reset_read_data", read_data, 32'd0);
    chk("reset_cmd_count", {16'b0, cmd_count}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (ready !== 1'b1 && n < 300);
    chk("init_latency", n, INITC);
    @(negedge clk);
    exp_cnt = '0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        wr;
    logic [23:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat;
    string nm;

    vecs[0] = '{1'b1, 24'h000000, 32'h12345688, 32'h00000000, WRL};
    vecs[1] = '{1'b0, 24'h000000, 32'h0,        32'h12345688, RDL};
    vecs[2] = '{1'b1, 24'h800001, 32'h12345600, 32'h12345688, WRL};
    vecs[3] = '{1'b1, 24'h820001, 32'h123456EE, 32'h12345688, WRL};
    vecs[4] = '{1'b0, 24'h800001, 32'h0,        32'h123456EE, RDL};
    vecs[5] = '{1'b1, 24'h000FFF, 32'hA5A5A5A5, 32'h123456EE, WRL};
    vecs[6] = '{1'b0, 24'hFFFFFF, 32'h0,        32'hA5A5A5A5, RDL};
    vecs[7] = '{1'b1, 24'h000005, 32'h00000055, 32'hA5A5A5A5, WRL};
    vecs[8] = '{1'b0, 24'h000005, 32'h0,        32'h00000055, RDL};
    vecs[9] = '{1'b0, 24'h000001, 32'h0,        32'h123456EE, RDL};

    do_reset();

    for (int i = 0; i < 10; i++) begin
      sync_refresh();
      do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].data, lat);
      exp_cnt++;
      nm = $sformatf("vec%0d", i);
      chk({nm, "_latency"}, lat, vecs[i].exp_lat);
      chk({nm, "_read_data"}, read_data, vecs[i].exp_rd);
      chk({nm, "_cmd_count"}, {16'b0, cmd_count}, {16'b0, exp_cnt});
    end

    // Held enable: second write accepted on first IDLE edge.
    sync_refresh();
    write = 1'b1;
    addr = 24'h000002;
    write_data = 32'h0BADF00D;
    enable = 1'b1;
    @(negedge clk);
    chk("held_accept", {31'b0, ready}, 32'd0);
    addr = 24'h000003;
    write_data = 32'hC0FFEE33;
    count_low(lat);
    chk("held_first_latency", lat, WRL);
    @(negedge clk);
    chk("held_ready_one_cycle", {31'b0, ready}, 32'd0);
    enable = 1'b0;
    count_low(lat);
    chk("held_second_latency", lat, WRL);
    exp_cnt += 16'd2;
    chk("held_cmd_count", {16'b0, cmd_count}, {16'b0, exp_cnt});
    chk("held_read_data_kept", read_data, 32'h123456EE);
    exp_q.push_back(32'h0BADF00D);
    exp_q.push_back(32'hC0FFEE33);
    for (int i = 0; i < 2; i++) begin
      sync_refresh();
      do_cmd(1'b0, 24'(2 + i), 32'h0, lat);
      exp_cnt++;
      chk("held_readback", read_data, exp_q.pop_front());
    end

    // Refresh collision: enable raised on the cycle refresh_pending sets.
    sync_refresh();
    sync_refresh();
    repeat (RP - RC - 1) @(negedge clk);
    chk("pre_collision_idle", {31'b0, ready}, 32'd1);
    write = 1'b0;
    addr = 24'h800001;
    enable = 1'b1;
    @(negedge clk);
    chk("collision_ready_low", {31'b0, ready}, 32'd0);
    count_low(lat);
    chk("collision_refresh_len", lat, RC);
    @(negedge clk);
    chk("collision_read_accept", {31'b0, ready}, 32'd0);
    enable = 1'b0;
    count_low(lat);
    chk("collision_read_latency", lat, RDL);
    chk("collision_read_data", read_data, 32'h123456EE);
    exp_cnt++;
    chk("collision_cmd_count", {16'b0, cmd_count}, {16'b0, exp_cnt});

    // Reset during a busy write: the write must not commit.
    sync_refresh();
    write = 1'b1;
    addr = 24'h000005;
    write_data = 32'hDEADBEEF;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    do_reset();
    sync_refresh();
    do_cmd(1'b0, 24'h000005, 32'h0, lat);
    exp_cnt++;
    chk("rst_busy_latency", lat, RDL);
    chk("rst_busy_read_data", read_data, 32'h00000055);
    chk("rst_busy_cmd_count", {16'b0, cmd_count}, {16'b0, exp_cnt});

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
